aes_key_expander: RTL and testbench



---
 rtl/aes_key_expander_if.sv | 21 ++
 rtl/aes_key_expander.sv | 160 ++++++++++++++++
 tb/tb_aes_key_expander.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// Key-load, status and round-key read port of the AES-128 key expander.
// The master side loads keys and reads round keys. The slave side is the expander.
interface aes_key_expander_if;
  logic         key_valid;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_ready;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  modport master (
    output key_valid, key_in, rd_idx,
    input  busy, done, keys_ready, rd_key
  );

  modport slave (
    input  key_valid, key_in, rd_idx,
    output busy, done, keys_ready, rd_key
  );
endinterface

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule. It produces one round key per clock into an
// 11-entry table, and the table is read back through a registered port.

module create_round_key (
  input  logic [127:0] rk,
  input  logic [3:0]   r_c,
  output logic [127:0] next_rk
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box computed as the multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3, rot, temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    case (r_c)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign {w0, w1, w2, w3} = rk;
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};
endmodule

module aes_key_expander (
  input logic               clk,
  input logic               rst,
  aes_key_expander_if.slave bus
);
  typedef enum logic {IDLE, EXPAND} state_t;

  state_t       state_q, state_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] cur_q, cur_d;
  logic         busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_data;
  logic [127:0] next_rk;
  logic [127:0] tbl [0:10];
  logic [127:0] rd_key_q;

  create_round_key u_crk (.rk(cur_q), .r_c(rc_q), .next_rk(next_rk));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= '0;
      cur_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // A key_valid during EXPAND, including the final edge, is dropped.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    cur_d   = cur_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    wr_en   = 1'b0;
    wr_idx  = rc_q + 4'd1;
    wr_data = next_rk;
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          state_d = EXPAND;
          rc_d    = 4'd0;
          cur_d   = bus.key_in;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_data = bus.key_in;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        cur_d = next_rk;
        rc_d  = rc_q + 4'd1;
        if (rc_q == 4'd9) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The read samples the table before this edge's write, so a same-index read returns the old key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) tbl[i] <= '0;
      rd_key_q <= '0;
    end else begin
      if (wr_en) tbl[wr_idx] <= wr_data;
      if (bus.rd_idx < 4'd11) rd_key_q <= tbl[bus.rd_idx];
      else                    rd_key_q <= '0;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.keys_ready = ready_q;
  assign bus.rd_key     = rd_key_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 and all-zero keys, ignored strobes,
// back-to-back loads, read sweep and mid-run reset.
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic rst = 1'b1;
  aes_key_expander_if bus ();

  aes_key_expander dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_tbl [0:10];

  initial begin
    fips_tbl[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_tbl[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_tbl[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_tbl[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_tbl[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_tbl[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_tbl[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_tbl[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_tbl[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_tbl[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_tbl[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_key(input int idx, output logic [127:0] val);
    bus.rd_idx = 4'(idx);
    step();
    val = bus.rd_key;
  endtask

  // Presents key_valid for one edge, so the edge after this task returns is E0.
  task automatic start_key(input logic [127:0] k);
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      cycles++;
      if (bus.done) return;
    end
    cycles = -1;
  endtask

  initial begin
    logic [127:0] v;
    int cyc, done_cnt, done_at, low_cnt;

    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rd_idx    = '0;
    #2;
    check("reset_busy", {127'd0, bus.busy}, 128'd0);
    check("reset_rd_key", bus.rd_key, 128'd0);
    step();
    rst = 1'b0;
    step();

    start_key(FIPS_KEY);
    check("fips_busy_after_accept", {127'd0, bus.busy}, 128'd1);
    wait_done(cyc);
    check("fips_done_latency", 128'(cyc), 128'd10);
    check("fips_ready_at_done", {127'd0, bus.keys_ready}, 128'd1);
    check("fips_busy_at_done", {127'd0, bus.busy}, 128'd0);
    step();
    check("fips_done_one_cycle", {127'd0, bus.done}, 128'd0);

    for (int i = 0; i < 16; i++) begin
      read_key(i, v);
      check($sformatf("sweep_idx%0d", i), v, (i <= 10) ? fips_tbl[i] : 128'd0);
    end

    start_key(128'd0);
    wait_done(cyc);
    check("zero_done_latency", 128'(cyc), 128'd10);
    read_key(1, v);
    check("zero_tbl1", v, ZERO_R1);
    read_key(10, v);
    check("zero_tbl10", v, ZERO_R10);

    // Strobes at cycles 3, 5 and 10 after accept carry the zero key and must be dropped.
    start_key(FIPS_KEY);
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= 25; c++) begin
      bus.key_valid = (c == 3 || c == 5 || c == 10);
      bus.key_in    = 128'd0;
      step();
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    bus.key_valid = 1'b0;
    check("ignore_done_count", 128'(done_cnt), 128'd1);
    check("ignore_done_cycle", 128'(done_at), 128'd10);
    read_key(1, v);
    check("ignore_tbl1", v, fips_tbl[1]);
    read_key(10, v);
    check("ignore_tbl10", v, fips_tbl[10]);

    start_key(FIPS_KEY);
    for (int c = 1; c <= 10; c++) step();
    check("b2b_first_done", {127'd0, bus.done}, 128'd1);
    start_key(128'd0);
    check("b2b_second_busy", {127'd0, bus.busy}, 128'd1);
    check("b2b_ready_dropped", {127'd0, bus.keys_ready}, 128'd0);
    low_cnt = 1;
    for (int i = 0; i < 30 && !bus.keys_ready; i++) begin
      step();
      if (!bus.keys_ready) low_cnt++;
    end
    check("b2b_ready_low_cycles", 128'(low_cnt), 128'd10);
    read_key(10, v);
    check("b2b_tbl10", v, ZERO_R10);

    start_key(FIPS_KEY);
    for (int c = 1; c <= 4; c++) step();
    rst = 1'b1;
    #1;
    check("rst_busy", {127'd0, bus.busy}, 128'd0);
    check("rst_done", {127'd0, bus.done}, 128'd0);
    check("rst_ready", {127'd0, bus.keys_ready}, 128'd0);
    check("rst_rd_key", bus.rd_key, 128'd0);
    step();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i <= 10; i++) begin
      read_key(i, v);
      if (bus.done) done_cnt++;
      check($sformatf("rst_tbl%0d", i), v, 128'd0);
    end
    check("rst_no_done", 128'(done_cnt), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
